// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output path: widths, pooling FSM
// states and the shift-and-saturate helper used by the output stages.
package conv_pkg;

    localparam int DATA_WIDTH_X = 8;
    localparam int DATA_WIDTH_F = 8;
    localparam int IN_WIDTH     = DATA_WIDTH_X + DATA_WIDTH_F + 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pool_state_t;

    // The caller passes a non-negative value. The result is clamped to the
    // largest value that fits in out_width unsigned bits.
    function automatic logic [31:0] sat_scale(input logic [31:0] m,
                                              input int          shift,
                                              input int          out_width);
        logic [31:0] v;
        logic [31:0] lim;
        v   = m >> shift;
        lim = (32'd1 << out_width) - 32'd1;
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/fifo_2deep.sv
// Two-entry in-order buffer. Count, head and pointers are all registered.
// The caller must not push when the buffer is full or pop when it is empty.
module fifo_2deep #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [0:1];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/relu_pool_out.sv
// ReLU, per-frame non-overlapping max-pooling, then shift-and-saturate to an
// unsigned byte. Results leave through a 2-entry buffer.
module relu_pool_out #(
    parameter int IN_WIDTH  = conv_pkg::IN_WIDTH,
    parameter int OUT_WIDTH = 8,
    parameter int NUM_IN    = 5,
    parameter int POOL      = 2,
    parameter int SHIFT     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid_y,
    output logic                 s_ready_y,
    input  logic [IN_WIDTH-1:0]  s_data_in_y,
    output logic                 m_valid_z,
    input  logic                 m_ready_z,
    output logic [OUT_WIDTH-1:0] m_data_out_z
);

    import conv_pkg::*;

    localparam int IN_CW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int WIN_CW = (POOL > 1) ? $clog2(POOL) : 1;

    // Handshakes: a beat moves on an edge where valid && ready are both high.
    // s_ready_y depends on registered state only, so it never follows m_ready_z.

    pool_state_t          state_q, state_d;
    logic [IN_WIDTH-1:0]  max_q, max_d;
    logic [IN_CW-1:0]     in_cnt, in_d;
    logic [WIN_CW-1:0]    win_cnt, win_d;
    logic                 rdy_q;
    logic [1:0]           fifo_count;
    logic [IN_WIDTH-1:0]  r;
    logic [IN_WIDTH-1:0]  merged;
    logic                 accept;
    logic                 closing;
    logic                 frame_end;
    logic                 push;
    logic                 pop;
    logic [OUT_WIDTH-1:0] push_data;

    assign s_ready_y = rdy_q && (fifo_count != 2'd2);
    assign accept    = s_valid_y && s_ready_y;
    assign r         = s_data_in_y[IN_WIDTH-1] ? '0 : s_data_in_y;
    assign merged    = ((state_q == ACCUM) && (max_q > r)) ? max_q : r;
    assign frame_end = (in_cnt == IN_CW'(NUM_IN - 1));
    assign closing   = (win_cnt == WIN_CW'(POOL - 1)) || frame_end;
    assign push_data = OUT_WIDTH'(sat_scale(32'(merged), SHIFT, OUT_WIDTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            max_q   <= '0;
            in_cnt  <= '0;
            win_cnt <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            in_cnt  <= in_d;
            win_cnt <= win_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        in_d    = in_cnt;
        win_d   = win_cnt;
        push    = 1'b0;
        if (accept) begin
            if (closing) begin
                push    = 1'b1;
                state_d = IDLE;
                win_d   = '0;
                in_d    = frame_end ? '0 : in_cnt + IN_CW'(1);
            end else begin
                state_d = ACCUM;
                max_d   = merged;
                win_d   = win_cnt + WIN_CW'(1);
                in_d    = in_cnt + IN_CW'(1);
            end
        end
    end

    assign m_valid_z = (fifo_count != 2'd0);
    assign pop       = m_valid_z && m_ready_z;

    fifo_2deep #(
        .WIDTH(OUT_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (m_data_out_z),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_relu_pool_out.sv
// Bench for relu_pool_out: directed frames plus random traffic, checked by a
// scoreboard fed from a frame/window reference model.
module tb_relu_pool_out;

    localparam int IW     = 18;
    localparam int OW     = 8;
    localparam int NUM_IN = 5;
    localparam int POOL   = 2;
    localparam int SHIFT  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid_y = 1'b0;
    logic          s_ready_y;
    logic [IW-1:0] s_data_in_y = '0;
    logic          m_valid_z;
    logic          m_ready_z = 1'b0;
    logic [OW-1:0] m_data_out_z;

    always #5 clk = ~clk;

    relu_pool_out #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .NUM_IN   (NUM_IN),
        .POOL     (POOL),
        .SHIFT    (SHIFT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid_y   (s_valid_y),
        .s_ready_y   (s_ready_y),
        .s_data_in_y (s_data_in_y),
        .m_valid_z   (m_valid_z),
        .m_ready_z   (m_ready_z),
        .m_data_out_z(m_data_out_z)
    );

    int            n_checks = 0;
    int            n_fail = 0;
    logic [OW-1:0] exp_q[$];
    int            win_vals[$];
    int            frame_pos = 0;
    bit            rand_rdy = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int ref_scale(input int m);
        int v;
        v = m >>> SHIFT;
        return (v > (2 ** OW) - 1) ? (2 ** OW) - 1 : v;
    endfunction

    // Reference: collect ReLU'd values of the open window; close it when it
    // holds POOL values or the frame has delivered NUM_IN beats.
    task automatic model_beat(input int x, output bit closed);
        int m;
        win_vals.push_back((x < 0) ? 0 : x);
        frame_pos++;
        closed = 1'b0;
        if (win_vals.size() == POOL || frame_pos == NUM_IN) begin
            m = 0;
            foreach (win_vals[i]) if (win_vals[i] > m) m = win_vals[i];
            exp_q.push_back(OW'(ref_scale(m)));
            win_vals.delete();
            if (frame_pos == NUM_IN) frame_pos = 0;
            closed = 1'b1;
        end
    endtask

    task automatic drive_beat(input int x, input bit lat_chk);
        bit acc;
        bit closed;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rand_rdy) m_ready_z = 1'($urandom_range(0, 1));
            s_valid_y   = 1'b1;
            s_data_in_y = IW'(x);
            acc = s_ready_y;
            @(posedge clk);
            if (acc) begin
                model_beat(x, closed);
                if (lat_chk && closed) begin
                    #1;
                    check("latency_valid", int'(m_valid_z), 1);
                    check("latency_data", int'(m_data_out_z), int'(exp_q[$]));
                end
                return;
            end
        end
        check("beat_accept_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid_y = 1'b0;
            if (rand_rdy) m_ready_z = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        s_valid_y = 1'b0;
        exp_q.delete();
        win_vals.delete();
        frame_pos = 0;
        #1;
        check("reset_m_valid", int'(m_valid_z), 0);
        check("reset_m_data", int'(m_data_out_z), 0);
        check("reset_s_ready", int'(s_ready_y), 0);
        repeat (2) @(negedge clk);
        check("reset_hold_valid", int'(m_valid_z), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", int'(s_ready_y), 1);
    endtask

    task automatic drain();
        int t;
        @(negedge clk);
        rand_rdy  = 1'b0;
        m_ready_z = 1'b1;
        s_valid_y = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: compare at every output handshake, and check that a stalled
    // output keeps its data until it is taken.
    logic [OW-1:0] held;
    bit            stalled = 1'b0;

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", int'(m_valid_z), 1);
                check("hold_data", int'(m_data_out_z), int'(held));
            end
            stalled = 1'b0;
            if (m_valid_z) begin
                if (m_ready_z) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL out_unexpected: got %0d, expected no output", m_data_out_z);
                    end else begin
                        check("out_data", int'(m_data_out_z), int'(exp_q.pop_front()));
                    end
                end else begin
                    stalled = 1'b1;
                    held    = m_data_out_z;
                end
            end
        end
    end

    initial begin
        int frame1[5] = '{32, 64, -16, 48, 100};
        int frame3[5] = '{5000, 1, 2, 3, 4};
        int frame4[5] = '{16, 32, 48, 64, 80};
        int frame5[5] = '{16, 32, 0, 0, 0};
        int x;

        #1;
        do_reset();

        m_ready_z = 1'b1;
        foreach (frame1[i]) drive_beat(frame1[i], 1'b1);
        for (int i = 0; i < 5; i++) drive_beat(-5, 1'b0);
        foreach (frame3[i]) drive_beat(frame3[i], 1'b0);
        drain();

        // Stall: two results fill the buffer and input back-pressure appears.
        m_ready_z = 1'b0;
        for (int i = 0; i < 4; i++) drive_beat(frame4[i], 1'b0);
        @(negedge clk);
        s_valid_y   = 1'b1;
        s_data_in_y = IW'(frame4[4]);
        #1;
        check("full_s_ready", int'(s_ready_y), 0);
        check("full_head", int'(m_data_out_z), 2);
        repeat (3) @(negedge clk);
        m_ready_z = 1'b1;
        drive_beat(frame4[4], 1'b0);
        drain();

        // Reset with a window open: the partial window must be discarded.
        drive_beat(80, 1'b0);
        do_reset();
        m_ready_z = 1'b1;
        foreach (frame5[i]) drive_beat(frame5[i], 1'b0);
        drain();

        // Two back-to-back frames, no gaps.
        for (int i = 1; i <= 10; i++) drive_beat(i * 16, 1'b0);
        drain();

        // Random traffic with random gaps and random output back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                x = int'($urandom_range(0, 131071)) - 65536;
            else
                x = int'($urandom_range(0, 6000)) - 1500;
            drive_beat(x, 1'b0);
            if ($urandom_range(0, 4) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
